// File: rtl/aes_fifo_batch_ctrl.sv
// Batch controller between host FIFOs and a byte-serial AES core.
// Loads up to DEPTH key/data pairs, feeds them back-to-back, collects results
// by strobe, then drains results and a status word to the output FIFO.
module aes_fifo_batch_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BYTE_W     = 8,
   parameter int unsigned DEPTH      = 16,
   parameter logic [31:0] TERM_WORD  = 32'h11110fff,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  data_empty,
   output logic                  data_rd,
   input  logic [DATA_WIDTH-1:0] data_din,
   input  logic                  data_full,
   output logic                  data_wr,
   output logic [DATA_WIDTH-1:0] data_dout,
   output logic                  core_in_vld,
   output logic [BYTE_W-1:0]     core_key,
   output logic [BYTE_W-1:0]     core_din,
   input  logic                  core_out_vld,
   input  logic [BYTE_W-1:0]     core_dout,
   output logic                  busy,
   output logic                  batch_done
);

   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned ToW  = $clog2(TIMEOUT + 1);
   localparam logic [DATA_WIDTH-1:0] TermExt    = DATA_WIDTH'(TERM_WORD);
   localparam logic [CntW-1:0]       DepthLast  = CntW'(DEPTH - 1);
   localparam logic [ToW-1:0]        TimeoutCnt = ToW'(TIMEOUT);

   typedef enum logic [2:0] {StIdle, StLoad, StFeed, StCollect, StDrain, StStatus} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   in_cnt_q, in_cnt_d;
   logic [CntW-1:0]   out_cnt_q, out_cnt_d;
   logic [CntW-1:0]   idx_q, idx_d;
   logic [2:0]        flags_q, flags_d;
   logic [ToW-1:0]    to_cnt_q, to_cnt_d;
   logic              core_in_vld_q;
   logic [BYTE_W-1:0] core_key_q, core_din_q;
   logic              batch_done_q;

   logic [BYTE_W-1:0] key_buf [DEPTH];
   logic [BYTE_W-1:0] dat_buf [DEPTH];
   logic [BYTE_W-1:0] res_buf [DEPTH];

   logic buf_we, res_we, is_term, capture;

   // State, counters, flags and registered core/handshake outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         in_cnt_q      <= '0;
         out_cnt_q     <= '0;
         idx_q         <= '0;
         flags_q       <= '0;
         to_cnt_q      <= '0;
         core_in_vld_q <= 1'b0;
         core_key_q    <= '0;
         core_din_q    <= '0;
         batch_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         in_cnt_q      <= in_cnt_d;
         out_cnt_q     <= out_cnt_d;
         idx_q         <= idx_d;
         flags_q       <= flags_d;
         to_cnt_q      <= to_cnt_d;
         core_in_vld_q <= (state_q == StFeed);
         core_key_q    <= (state_q == StFeed) ? key_buf[idx_q[IdxW-1:0]] : '0;
         core_din_q    <= (state_q == StFeed) ? dat_buf[idx_q[IdxW-1:0]] : '0;
         batch_done_q  <= (state_q == StStatus) && data_wr;
      end
   end

   // Pair and result storage; contents are don't-care after reset
   always_ff @(posedge clock) begin
      if (buf_we) begin
         key_buf[in_cnt_q[IdxW-1:0]] <= data_din[2*BYTE_W-1:BYTE_W];
         dat_buf[in_cnt_q[IdxW-1:0]] <= data_din[BYTE_W-1:0];
      end
      if (res_we) begin
         res_buf[out_cnt_q[IdxW-1:0]] <= core_dout;
      end
   end

   // Next-state, result capture and FIFO handshakes
   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      idx_d     = idx_q;
      flags_d   = flags_q;
      to_cnt_d  = to_cnt_q;
      buf_we    = 1'b0;
      res_we    = 1'b0;
      data_rd   = 1'b0;
      data_wr   = 1'b0;
      data_dout = '0;
      is_term   = (data_din == TermExt);
      capture   = ((state_q == StFeed) || (state_q == StCollect)) && core_out_vld;

      if (capture) begin
         if (out_cnt_q != in_cnt_q) begin
            res_we    = 1'b1;
            out_cnt_d = out_cnt_q + 1'b1;
            to_cnt_d  = '0;
         end else begin
            flags_d[1] = 1'b1;
         end
      end

      unique case (state_q)
         StIdle: begin
            in_cnt_d  = '0;
            out_cnt_d = '0;
            idx_d     = '0;
            flags_d   = '0;
            to_cnt_d  = '0;
            if (!data_empty) state_d = StLoad;
         end
         StLoad: begin
            if (!data_empty) begin
               data_rd = 1'b1;
               if (is_term) begin
                  state_d = (in_cnt_q != '0) ? StFeed : StStatus;
               end else begin
                  buf_we   = 1'b1;
                  in_cnt_d = in_cnt_q + 1'b1;
                  if (in_cnt_q == DepthLast) begin
                     state_d    = StFeed;
                     flags_d[2] = 1'b1;
                  end
               end
            end
         end
         StFeed: begin
            if (idx_q == in_cnt_q - 1'b1) begin
               idx_d   = '0;
               state_d = StCollect;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StCollect: begin
            if (out_cnt_q == in_cnt_q) begin
               state_d = StDrain;
            end else if (to_cnt_q == TimeoutCnt) begin
               // With no result at all there is nothing to drain
               flags_d[0] = 1'b1;
               state_d    = (out_cnt_d != '0) ? StDrain : StStatus;
            end else if (!res_we) begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         StDrain: begin
            // Only entered with out_cnt > 0
            data_dout = DATA_WIDTH'(res_buf[idx_q[IdxW-1:0]]);
            data_wr   = !data_full;
            if (data_wr) begin
               if (idx_q == out_cnt_q - 1'b1) begin
                  idx_d   = '0;
                  state_d = StStatus;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StStatus: begin
            data_dout = DATA_WIDTH'({8'hA5, 5'b0, flags_q, 8'(in_cnt_q), 8'(out_cnt_q)});
            data_wr   = !data_full;
            if (data_wr) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign core_in_vld = core_in_vld_q;
   assign core_key    = core_key_q;
   assign core_din    = core_din_q;
   assign busy        = (state_q != StIdle);
   assign batch_done  = batch_done_q;

endmodule

// File: tb/tb_aes_fifo_batch_ctrl.sv
// Self-checking bench: FIFO and core models around the batch controller,
// a queue-based reference model of the batching rules, and a vector table.
module tb_aes_fifo_batch_ctrl;

   localparam int          Depth   = 16;
   localparam int          Timeout = 64;
   localparam logic [31:0] Term    = 32'h11110fff;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        data_empty, data_rd, data_full, data_wr;
   logic [31:0] data_din, data_dout;
   logic        core_in_vld, core_out_vld, busy, batch_done;
   logic [7:0]  core_key, core_din, core_dout;

   aes_fifo_batch_ctrl #(
      .DATA_WIDTH(32),
      .BYTE_W    (8),
      .DEPTH     (Depth),
      .TERM_WORD (Term),
      .TIMEOUT   (Timeout)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .data_empty  (data_empty),
      .data_rd     (data_rd),
      .data_din    (data_din),
      .data_full   (data_full),
      .data_wr     (data_wr),
      .data_dout   (data_dout),
      .core_in_vld (core_in_vld),
      .core_key    (core_key),
      .core_din    (core_din),
      .core_out_vld(core_out_vld),
      .core_dout   (core_dout),
      .busy        (busy),
      .batch_done  (batch_done)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          due;
      logic [7:0]  val;
   } rsp_t;

   typedef struct {
      int          np;
      bit          term;
      int          fm;
      int          flt;
      logic [31:0] st0;
      int          nw;
   } vec_t;

   int          total = 0;
   int          bad = 0;
   logic [31:0] in_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] stat_q[$];
   logic [31:0] stim_q[$];
   logic [7:0]  mres_q[$];
   rsp_t        rsp_q[$];
   int          cyc = 0;
   int          fed_n = 0;
   int          fault = 0;
   int          full_mode = 0;
   bit          empty_rand = 1'b0;
   int          pushes = 0;
   int          last_rsp_cyc = 0;
   int          status_cyc = 0;
   bit          done_exp = 1'b0;
   vec_t        vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference model: batches close on the terminator or on the DEPTH-th pair
   task automatic emit(input int n, input logic [2:0] fl_in, input int flt);
      logic [2:0] fl;
      fl = fl_in;
      if (flt == 1 && mres_q.size() >= 2) begin
         mres_q.delete(1);
         fl[0] = 1'b1;
      end
      if (flt == 2) fl[1] = 1'b1;
      foreach (mres_q[i]) exp_q.push_back({24'h0, mres_q[i]});
      exp_q.push_back({8'hA5, 5'b0, fl, 8'(n), 8'(mres_q.size())});
      mres_q.delete();
   endtask

   task automatic model(input int flt);
      int n;
      n = 0;
      mres_q.delete();
      foreach (stim_q[i]) begin
         if (stim_q[i] == Term) begin
            emit(n, 3'b000, flt);
            n = 0;
         end else begin
            mres_q.push_back(stim_q[i][15:8] ^ stim_q[i][7:0]);
            n++;
            if (n == Depth) begin
               emit(n, 3'b100, flt);
               n = 0;
            end
         end
      end
   endtask

   initial begin
      data_empty   = 1'b1;
      data_din     = '0;
      data_full    = 1'b0;
      core_out_vld = 1'b0;
      core_dout    = '0;
   end

   // FIFO and core models: sample mid-cycle, drive just after the rising edge
   always begin
      @(negedge clock);
      if (reset_n) begin
         if (data_rd && in_q.size() != 0) in_q.delete(0);
         if (core_in_vld) begin
            if (!(fault == 1 && fed_n == 1)) rsp_q.push_back('{due: cyc + 3, val: core_key ^ core_din});
            if (fault == 2 && fed_n == 3) rsp_q.push_back('{due: cyc + 4, val: 8'hEE});
            fed_n++;
         end
         if (batch_done || done_exp) check("batch_done", {31'b0, batch_done}, {31'b0, done_exp});
         done_exp = 1'b0;
         if (data_wr) begin
            pushes++;
            if (data_dout[31:24] == 8'hA5) begin
               stat_q.push_back(data_dout);
               status_cyc = cyc;
               done_exp   = 1'b1;
            end
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_push: got %h want none", data_dout);
            end else begin
               check("out_word", data_dout, exp_q.pop_front());
            end
         end
      end
      @(posedge clock);
      #1;
      cyc++;
      if (full_mode == 1)      data_full = (cyc % 2 == 1);
      else if (full_mode == 2) data_full = ($urandom_range(0, 2) == 0);
      else                     data_full = 1'b0;
      data_empty   = (in_q.size() == 0) || (empty_rand && $urandom_range(0, 3) == 0);
      data_din     = (in_q.size() != 0) ? in_q[0] : 32'h0;
      core_out_vld = 1'b0;
      core_dout    = '0;
      if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
         core_out_vld = 1'b1;
         core_dout    = rsp_q[0].val;
         last_rsp_cyc = cyc;
         rsp_q.delete(0);
      end
   end

   task automatic run_case(input int np, input bit term, input int fm, input int flt, input bit rnd);
      logic [7:0] k, d;
      int         c;
      stim_q.delete();
      for (int i = 0; i < np; i++) begin
         k = rnd ? 8'($urandom) : 8'(i);
         d = rnd ? 8'($urandom) : 8'(8'h10 + i);
         stim_q.push_back({16'h0, k, d});
      end
      if (term) stim_q.push_back(Term);
      model(flt);
      fault      = flt;
      full_mode  = fm;
      empty_rand = rnd;
      fed_n      = 0;
      pushes     = 0;
      stat_q.delete();
      foreach (stim_q[i]) in_q.push_back(stim_q[i]);
      c = 0;
      while (c < 4000 && (exp_q.size() != 0 || in_q.size() != 0 || rsp_q.size() != 0 || busy)) begin
         @(negedge clock);
         c++;
      end
      check("case_leftover", exp_q.size(), 0);
      check("case_idle", {31'b0, busy}, 32'h0);
      repeat (2) @(negedge clock);
   endtask

   initial begin
      logic [31:0] s0;
      int          gap;
      int          c;
      // 16 pairs close the batch implicitly, so the trailing terminator opens an empty one
      vecs[0] = '{np: 16, term: 1'b1, fm: 0, flt: 0, st0: 32'hA504_1010, nw: 18};
      vecs[1] = '{np: 3,  term: 1'b1, fm: 1, flt: 0, st0: 32'hA500_0303, nw: 4};
      vecs[2] = '{np: 0,  term: 1'b1, fm: 0, flt: 0, st0: 32'hA500_0000, nw: 1};
      vecs[3] = '{np: 17, term: 1'b1, fm: 0, flt: 0, st0: 32'hA504_1010, nw: 19};
      vecs[4] = '{np: 4,  term: 1'b1, fm: 0, flt: 1, st0: 32'hA501_0403, nw: 4};
      vecs[5] = '{np: 4,  term: 1'b1, fm: 0, flt: 2, st0: 32'hA502_0404, nw: 5};

      repeat (3) @(posedge clock);
      #2;
      check("rst_data_rd",     {31'b0, data_rd},     32'h0);
      check("rst_data_wr",     {31'b0, data_wr},     32'h0);
      check("rst_data_dout",   data_dout,            32'h0);
      check("rst_core_in_vld", {31'b0, core_in_vld}, 32'h0);
      check("rst_core_key",    {24'b0, core_key},    32'h0);
      check("rst_core_din",    {24'b0, core_din},    32'h0);
      check("rst_busy",        {31'b0, busy},        32'h0);
      check("rst_batch_done",  {31'b0, batch_done},  32'h0);
      reset_n = 1'b1;
      @(negedge clock);

      for (int v = 0; v < 6; v++) begin
         run_case(vecs[v].np, vecs[v].term, vecs[v].fm, vecs[v].flt, 1'b0);
         s0 = (stat_q.size() != 0) ? stat_q[0] : 32'h0;
         check($sformatf("vec%0d_status", v), s0, vecs[v].st0);
         check($sformatf("vec%0d_pushes", v), pushes, vecs[v].nw);
         check($sformatf("vec%0d_feeds", v), fed_n, vecs[v].np);
         if (vecs[v].flt == 1) begin
            gap = status_cyc - last_rsp_cyc;
            check("timeout_gap", {31'b0, (gap >= Timeout && gap <= Timeout + 8)}, 32'h1);
         end
      end

      // Reset pulsed while feeding the core
      fault = 0;
      full_mode = 0;
      empty_rand = 1'b0;
      for (int i = 0; i < 8; i++) in_q.push_back({16'h0, 8'(i), 8'(8'h40 + i)});
      in_q.push_back(Term);
      c = 0;
      while (c < 200 && !core_in_vld) begin
         @(negedge clock);
         c++;
      end
      check("feed_started", {31'b0, core_in_vld}, 32'h1);
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_data_rd",     {31'b0, data_rd},     32'h0);
      check("arst_data_wr",     {31'b0, data_wr},     32'h0);
      check("arst_data_dout",   data_dout,            32'h0);
      check("arst_core_in_vld", {31'b0, core_in_vld}, 32'h0);
      check("arst_core_key",    {24'b0, core_key},    32'h0);
      check("arst_core_din",    {24'b0, core_din},    32'h0);
      check("arst_busy",        {31'b0, busy},        32'h0);
      check("arst_batch_done",  {31'b0, batch_done},  32'h0);
      in_q.delete();
      rsp_q.delete();
      exp_q.delete();
      done_exp = 1'b0;
      @(posedge clock);
      #3;
      reset_n = 1'b1;
      @(negedge clock);
      run_case(3, 1'b1, 2, 0, 1'b1);
      s0 = (stat_q.size() != 0) ? stat_q[0] : 32'h0;
      check("post_reset_status", s0, 32'hA500_0303);

      // Randomised batches with input stalls and output backpressure
      for (int r = 0; r < 10; r++) begin
         run_case($urandom_range(0, 20), 1'b1, 2, 0, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      bad++;
      $display("FAIL watchdog: got no finish want finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
